// File: rtl/mem_responder.sv
// Program/data memory responder: downloads a program into program RAM while holding the CPU in reset, then serves it.
// Zero-cycle combinational reads; loadReady is high only in LOAD, so the loader is stalled in every other state.
module mem_responder #(
    parameter int WIDTH = 16,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    programAddress,
    output logic [WIDTH-1:0] programData,
    input  logic [AW-1:0]    dataAddress,
    input  logic [WIDTH-1:0] writeData,
    input  logic             WE,
    output logic [WIDTH-1:0] readData,
    input  logic             loadStart,
    input  logic             loadValid,
    input  logic [WIDTH-1:0] loadData,
    input  logic             loadLast,
    output logic             loadReady,
    output logic             cpuReset,
    output logic [AW:0]      loadCount,
    output logic             loadOverflow
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {HOLD, LOAD, DRAIN, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          accept;
    logic          restart;

    logic [WIDTH-1:0] progMem [DEPTH];
    logic [WIDTH-1:0] dataMem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HOLD;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD:    if (loadStart) state_d = LOAD;
            LOAD:    if (accept && loadLast) state_d = DRAIN;
            DRAIN:   state_d = RUN;
            RUN:     if (loadStart) state_d = LOAD;
            default: state_d = HOLD;
        endcase
    end

    always_comb begin
        cpuReset  = (state_q != RUN);
        loadReady = (state_q == LOAD);
    end

    assign accept  = loadReady && loadValid;
    assign restart = loadStart && (state_q == HOLD || state_q == RUN);

    // Count saturates at DEPTH; the sticky overflow flag records the pointer wrap.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (restart) begin
            ptr_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == {AW{1'b1}}) ovf_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) progMem[ptr_q] <= loadData;
    end

    always_ff @(posedge clk) begin
        if (state_q == RUN && WE) dataMem[dataAddress] <= writeData;
    end

    assign programData  = progMem[programAddress];
    assign readData     = dataMem[dataAddress];
    assign loadCount    = cnt_q;
    assign loadOverflow = ovf_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder with an array-based model of both RAMs and the download counters.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  programAddress, dataAddress;
    logic [15:0] programData, readData, writeData, loadData;
    logic        WE, loadStart, loadValid, loadLast;
    logic        loadReady, cpuReset, loadOverflow;
    logic [10:0] loadCount;

    mem_responder #(.WIDTH(16), .AW(10)) dut (
        .clk(clk), .reset(rst_n),
        .programAddress(programAddress), .programData(programData),
        .dataAddress(dataAddress), .writeData(writeData), .WE(WE), .readData(readData),
        .loadStart(loadStart), .loadValid(loadValid), .loadData(loadData), .loadLast(loadLast),
        .loadReady(loadReady), .cpuReset(cpuReset), .loadCount(loadCount), .loadOverflow(loadOverflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] prog_m [1024];
    bit          prog_v [1024];
    logic [15:0] data_m [1024];
    bit          data_v [1024];
    int          exp_cnt;
    bit          exp_ovf;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a download (from HOLD or RUN), send n words, and follow it through DRAIN into RUN.
    task automatic do_load(input int n, input bit gaps, input bit junk);
        int acc;
        int cyc;
        logic [15:0] w;
        acc = 0;
        cyc = 0;
        WE = 1'b0;
        loadStart = 1'b1; loadValid = junk; loadData = 16'($urandom); loadLast = junk;
        #1;
        n_tests++; if (loadReady !== 1'b0) begin n_fail++; $display("FAIL start_rdy: got %b want 0", loadReady); end
        step();
        loadStart = 1'b0; loadValid = 1'b0; loadLast = 1'b0;
        #1;
        n_tests++; if (cpuReset !== 1'b1 || loadCount !== 11'd0 || loadOverflow !== 1'b0) begin
            n_fail++; $display("FAIL enter_load: cpuReset=%b cnt=%0d ovf=%b want 1/0/0", cpuReset, loadCount, loadOverflow); end
        while (acc < n) begin
            WE = 1'($urandom); dataAddress = 10'($urandom); writeData = 16'($urandom);
            if (gaps && cyc[0]) begin
                loadValid = 1'b0; loadLast = 1'($urandom); loadData = 16'($urandom); loadStart = 1'($urandom);
            end else begin
                w = 16'($urandom);
                loadValid = 1'b1; loadData = w; loadLast = (acc == n - 1); loadStart = gaps ? 1'($urandom) : 1'b0;
                prog_m[acc % 1024] = w; prog_v[acc % 1024] = 1'b1;
                acc++;
            end
            cyc++;
            #1;
            if (loadReady !== 1'b1 || cpuReset !== 1'b1) begin
                n_tests++; n_fail++; $display("FAIL load_state: rdy=%b cpuReset=%b want 1/1", loadReady, cpuReset); end
            step();
        end
        exp_cnt = (n > 1024) ? 1024 : n;
        exp_ovf = (n > 1024);
        loadValid = 1'b0; loadLast = 1'b0; loadStart = 1'($urandom);
        #1;
        n_tests++; if (cpuReset !== 1'b1 || loadReady !== 1'b0) begin
            n_fail++; $display("FAIL drain: cpuReset=%b rdy=%b want 1/0", cpuReset, loadReady); end
        step();
        loadStart = 1'b0; WE = 1'b0;
        #1;
        n_tests++; if (cpuReset !== 1'b0 || loadReady !== 1'b0) begin
            n_fail++; $display("FAIL run_entry: cpuReset=%b rdy=%b want 0/0", cpuReset, loadReady); end
        n_tests++; if (loadCount !== 11'(exp_cnt) || loadOverflow !== exp_ovf) begin
            n_fail++; $display("FAIL load_result: cnt=%0d ovf=%b want %0d/%b", loadCount, loadOverflow, exp_cnt, exp_ovf); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        WE = 0; loadStart = 0; loadValid = 0; loadLast = 0; loadData = 0;
        programAddress = 0; dataAddress = 0; writeData = 0;
        for (int i = 0; i < 1024; i++) begin prog_v[i] = 0; data_v[i] = 0; end
        #12;
        n_tests++; if (cpuReset !== 1'b1 || loadReady !== 1'b0 || loadCount !== 11'd0 || loadOverflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: cpuReset=%b rdy=%b cnt=%0d ovf=%b", cpuReset, loadReady, loadCount, loadOverflow); end
        #11 rst_n = 1'b1;
        loadValid = 1'b1; loadLast = 1'b1; WE = 1'b1;
        for (int i = 0; i < 4; i++) step();
        loadValid = 1'b0; loadLast = 1'b0; WE = 1'b0;
        n_tests++; if (cpuReset !== 1'b1 || loadReady !== 1'b0 || loadCount !== 11'd0) begin
            n_fail++; $display("FAIL hold_after_reset: cpuReset=%b rdy=%b cnt=%0d want 1/0/0", cpuReset, loadReady, loadCount); end
    endtask

    task automatic test_basic_load();
        logic [15:0] words [3];
        words[0] = 16'h1001; words[1] = 16'h2002; words[2] = 16'h3003;
        loadStart = 1'b1; loadValid = 1'b1; loadData = 16'hDEAD; #1;
        n_tests++; if (loadReady !== 1'b0) begin n_fail++; $display("FAIL basic_start_rdy: got %b want 0", loadReady); end
        step();
        loadStart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            loadValid = 1'b1; loadData = words[i]; loadLast = (i == 2);
            prog_m[i] = words[i]; prog_v[i] = 1'b1;
            step();
        end
        loadValid = 1'b0; loadLast = 1'b0; #1;
        n_tests++; if (cpuReset !== 1'b1 || loadCount !== 11'd3) begin
            n_fail++; $display("FAIL basic_drain: cpuReset=%b cnt=%0d want 1/3", cpuReset, loadCount); end
        step();
        n_tests++; if (cpuReset !== 1'b0) begin n_fail++; $display("FAIL basic_release: cpuReset=%b want 0", cpuReset); end
        for (int i = 0; i < 3; i++) begin
            programAddress = 10'(i); #1;
            n_tests++; if (programData !== words[i]) begin
                n_fail++; $display("FAIL basic_prog[%0d]: got %h want %h", i, programData, words[i]); end
        end
    endtask

    task automatic test_data_write();
        logic [9:0]  a;
        logic [15:0] d;
        dataAddress = 10'h3FE; writeData = 16'hBEEF; WE = 1'b1;
        step();
        WE = 1'b0; data_m[10'h3FE] = 16'hBEEF; data_v[10'h3FE] = 1'b1; #1;
        n_tests++; if (readData !== 16'hBEEF) begin n_fail++; $display("FAIL data_beef: got %h want beef", readData); end
        for (int k = 0; k < 20; k++) begin
            a = 10'($urandom_range(0, 1021)); d = 16'($urandom);
            dataAddress = a; writeData = d; WE = 1'b1;
            step();
            WE = 1'b0; data_m[a] = d; data_v[a] = 1'b1; #1;
            n_tests++; if (readData !== d) begin n_fail++; $display("FAIL data_rand[%h]: got %h want %h", a, readData, d); end
        end
    endtask

    task automatic test_gapped_load();
        do_load(12, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            programAddress = 10'(i); #1;
            n_tests++; if (programData !== prog_m[i]) begin
                n_fail++; $display("FAIL gapped_prog[%0d]: got %h want %h", i, programData, prog_m[i]); end
        end
    endtask

    task automatic test_overflow();
        do_load(1025, 1'b0, 1'b1);
        for (int i = 0; i < 1024; i++) begin
            programAddress = 10'(i); #1;
            n_tests++; if (programData !== prog_m[i]) begin
                n_fail++; $display("FAIL ovf_prog[%0d]: got %h want %h", i, programData, prog_m[i]); end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] w;
        loadStart = 1'b1; step(); loadStart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom);
            loadValid = 1'b1; loadData = w; loadLast = 1'b0;
            prog_m[i] = w;
            step();
        end
        loadValid = 1'b1; loadData = 16'($urandom);
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (cpuReset !== 1'b1 || loadReady !== 1'b0 || loadCount !== 11'd0 || loadOverflow !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: cpuReset=%b rdy=%b cnt=%0d ovf=%b want 1/0/0/0", cpuReset, loadReady, loadCount, loadOverflow); end
        #2 rst_n = 1'b1;
        dataAddress = 10'h3FE; writeData = 16'h1234; WE = 1'b1;
        for (int i = 0; i < 3; i++) step();
        WE = 1'b0; loadValid = 1'b0; #1;
        n_tests++; if (readData !== 16'hBEEF) begin n_fail++; $display("FAIL hold_we: got %h want beef", readData); end
        n_tests++; if (cpuReset !== 1'b1 || loadCount !== 11'd0) begin
            n_fail++; $display("FAIL hold_stay: cpuReset=%b cnt=%0d want 1/0", cpuReset, loadCount); end
        for (int i = 0; i < 1024; i++) begin
            programAddress = 10'(i); #1;
            n_tests++; if (programData !== prog_m[i]) begin
                n_fail++; $display("FAIL retained_prog[%0d]: got %h want %h", i, programData, prog_m[i]); end
        end
    endtask

    task automatic test_reload_in_run();
        do_load(5, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            do_load($urandom_range(1, 40), 1'($urandom), 1'b0);
            for (int i = 0; i < 1024; i++) begin
                if (data_v[i]) begin
                    dataAddress = 10'(i); #1;
                    n_tests++; if (readData !== data_m[i]) begin
                        n_fail++; $display("FAIL reload_data[%0d]: got %h want %h", i, readData, data_m[i]); end
                end
            end
            for (int i = 0; i < 1024; i++) begin
                programAddress = 10'(i); #1;
                n_tests++; if (programData !== prog_m[i]) begin
                    n_fail++; $display("FAIL reload_prog[%0d]: got %h want %h", i, programData, prog_m[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_data_write();
        test_gapped_load();
        test_overflow();
        test_reset_mid_load();
        test_reload_in_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
